// File: rtl/eth_pkg.sv
// eth_pkg: shared widths and the packet arbiter state encoding for the TX path.
package eth_pkg;

    localparam int ETH_DATA_W = 16;

    // Byte-count field wide enough to hold 0..DATA_W/8 valid bytes.
    function automatic int eth_len_w(input int data_w);
        return $clog2(data_w / 8 + 1);
    endfunction

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; search starts one past ptr.
module rr_pick #(
    parameter  int N_REQ = 2,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic [PTR_W-1:0] idx;

    // Walk the ring from ptr+1, wrapping at N_REQ; the first pending request wins.
    always_comb begin
        gnt = '0;
        idx = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tx_pkt_arb.sv
// tx_pkt_arb: round-robin packet arbiter in front of the IPv4 TX stage.
// A packet owns the bus from grant to its last accepted beat; a stalled or
// malformed packet is aborted with a one-cycle cancel_o pulse.
module tx_pkt_arb
    import eth_pkg::*;
#(
    parameter  int DATA_W  = ETH_DATA_W,
    parameter  int N_REQ   = 2,
    parameter  int TIMEOUT = 64,
    localparam int LEN_W   = eth_len_w(DATA_W)
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        valid_i,
    input  logic [N_REQ-1:0]        start_i,
    input  logic [N_REQ-1:0]        last_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    input  logic [N_REQ*LEN_W-1:0]  len_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic [N_REQ-1:0]        ready_o,
    output logic                    valid_o,
    output logic                    start_o,
    output logic                    last_o,
    output logic [DATA_W-1:0]       data_o,
    output logic [LEN_W-1:0]        len_o,
    input  logic                    ready_i,
    output logic                    cancel_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e       state_q;
    logic [N_REQ-1:0] grant_q;
    logic [PTR_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             cancel_q;

    logic [N_REQ-1:0][DATA_W-1:0] data_lane;
    logic [N_REQ-1:0][LEN_W-1:0]  len_lane;
    logic [N_REQ-1:0]             pick;
    logic [PTR_W-1:0]             g_idx;
    logic                         xfer;
    logic                         acc;
    logic                         proto_err;
    logic                         pkt_done;
    logic                         tmo;

    assign xfer = (state_q == ARB_XFER);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign data_lane[gi] = data_i[gi*DATA_W +: DATA_W];
            assign len_lane[gi]  = len_i[gi*LEN_W +: LEN_W];
            assign ready_o[gi]   = grant_q[gi] & ready_i & xfer;
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // Zero-latency output mux from the granted lane; all zero with no grant.
    always_comb begin
        valid_o = 1'b0;
        start_o = 1'b0;
        last_o  = 1'b0;
        data_o  = '0;
        len_o   = '0;
        g_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                valid_o = valid_i[i] & xfer;
                start_o = start_i[i];
                last_o  = last_i[i];
                data_o  = data_lane[i];
                len_o   = len_lane[i];
                g_idx   = PTR_W'(i);
            end
        end
    end

    // Packet-end conditions: clean last beat, missing start on first beat, stall timeout.
    always_comb begin
        acc       = valid_o & ready_i;
        proto_err = acc & first_q & ~start_o;
        pkt_done  = acc & last_o;
        tmo       = xfer & ~acc & (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    assign grant_o  = grant_q;
    assign cancel_o = cancel_q;

    // Arbiter FSM: grant in IDLE, hold ownership in XFER until the packet ends.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            ptr_q    <= PTR_W'(N_REQ - 1);
            cnt_q    <= '0;
            first_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            cancel_q <= 1'b0;
            if (!xfer) begin
                if (|req_i) begin
                    state_q <= ARB_XFER;
                    grant_q <= pick;
                    cnt_q   <= '0;
                    first_q <= 1'b1;
                end
            end else begin
                // Any accepted beat restarts the stall window.
                if (acc) begin
                    cnt_q   <= '0;
                    first_q <= 1'b0;
                end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (proto_err || pkt_done || tmo) begin
                    state_q  <= ARB_IDLE;
                    grant_q  <= '0;
                    ptr_q    <= g_idx;
                    cancel_q <= proto_err | tmo;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_pkt_arb.sv
// tb_tx_pkt_arb: vector table, hand-written corner sequences and a
// randomized run against a packet-level reference model.
module tb_tx_pkt_arb;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int LW = 2;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          nreset;
    logic [N-1:0]  req_i, valid_i, start_i, last_i, grant_o, ready_o;
    logic [N*DW-1:0] data_i;
    logic [N*LW-1:0] len_i;
    logic          valid_o, start_o, last_o, ready_i, cancel_o;
    logic [DW-1:0] data_o;
    logic [LW-1:0] len_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_pkt_arb #(.DATA_W(DW), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .nreset(nreset),
        .req_i(req_i), .valid_i(valid_i), .start_i(start_i), .last_i(last_i),
        .data_i(data_i), .len_i(len_i),
        .grant_o(grant_o), .ready_o(ready_o),
        .valid_o(valid_o), .start_o(start_o), .last_o(last_o),
        .data_o(data_o), .len_o(len_o),
        .ready_i(ready_i), .cancel_o(cancel_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the edge; outputs sampled 2 ns later.
    task automatic drive(input logic nrst, input logic [1:0] req, input logic [1:0] vld,
                         input logic [1:0] st, input logic [1:0] ls, input logic rdy,
                         input logic [15:0] d0, input logic [15:0] d1);
        @(posedge clk); #1;
        nreset = nrst; req_i = req; valid_i = vld; start_i = st; last_i = ls;
        ready_i = rdy; data_i = {d1, d0};
        #1;
    endtask

    // Reference model: owner index (-1 = none), previous owner, stall count.
    int m_own, m_last, m_idle;
    bit m_first, m_cancel;

    task automatic model_check();
        logic [N-1:0] eg, er;
        logic ev, es, el;
        logic [DW-1:0] ed;
        logic [LW-1:0] elen;
        eg = '0; er = '0; ev = 0; es = 0; el = 0; ed = '0; elen = '0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ev   = valid_i[m_own];
            es   = start_i[m_own];
            el   = last_i[m_own];
            ed   = data_i[m_own*DW +: DW];
            elen = len_i[m_own*LW +: LW];
            er   = ready_i ? eg : '0;
        end
        chk("rand_outputs",
            64'({grant_o, ready_o, valid_o, start_o, last_o, data_o, len_o, cancel_o}),
            64'({eg, er, ev, es, el, ed, elen, m_cancel}));
    endtask

    task automatic model_step();
        bit found;
        int c;
        if (!nreset) begin
            m_own = -1; m_last = N - 1; m_idle = 0; m_first = 0; m_cancel = 0;
            return;
        end
        m_cancel = 0;
        if (m_own < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && req_i[c]) begin
                    found = 1; m_own = c;
                end
            end
            if (found) begin m_idle = 0; m_first = 1; end
        end else if (valid_i[m_own] && ready_i) begin
            m_idle = 0;
            if (m_first && !start_i[m_own]) begin
                m_cancel = 1; m_last = m_own; m_own = -1;
            end else if (last_i[m_own]) begin
                m_last = m_own; m_own = -1;
            end
            m_first = 0;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_cancel = 1; m_last = m_own; m_own = -1;
            end
        end
    endtask

    typedef struct {
        logic        nrst;
        logic [1:0]  req, vld, st, ls;
        logic [15:0] d0, d1;
        logic        rdy;
        logic [1:0]  eg;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  er;
        logic        ec;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int stall_left;
        logic [1:0] r, v, s, l;

        nreset = 0; req_i = '0; valid_i = '0; start_i = '0; last_i = '0;
        ready_i = 0; data_i = '0; len_i = {2'd1, 2'd2};

        //          nrst req   vld   st    ls    d0        d1        rdy  grant ev  data      ready cancel
        tbl[0]  = '{0, 2'b10, 2'b10, 2'b10, 2'b10, 16'h0000, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 0};
        tbl[1]  = '{1, 2'b10, 2'b10, 2'b10, 2'b10, 16'h0000, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 0};
        tbl[2]  = '{1, 2'b00, 2'b10, 2'b10, 2'b10, 16'h0000, 16'hA5A5, 1, 2'b10, 1, 16'hA5A5, 2'b10, 0};
        tbl[3]  = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 0};
        tbl[4]  = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 16'h1111, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 0};
        tbl[5]  = '{1, 2'b11, 2'b01, 2'b01, 2'b00, 16'h1111, 16'hA5A5, 0, 2'b01, 1, 16'h1111, 2'b00, 0};
        tbl[6]  = '{1, 2'b11, 2'b01, 2'b01, 2'b00, 16'h1111, 16'hA5A5, 1, 2'b01, 1, 16'h1111, 2'b01, 0};
        tbl[7]  = '{1, 2'b11, 2'b01, 2'b00, 2'b01, 16'h2222, 16'hA5A5, 1, 2'b01, 1, 16'h2222, 2'b01, 0};
        tbl[8]  = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 16'h2222, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 0};
        tbl[9]  = '{1, 2'b11, 2'b10, 2'b00, 2'b00, 16'h2222, 16'hA5A5, 1, 2'b10, 1, 16'hA5A5, 2'b10, 0};
        tbl[10] = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 16'h2222, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 1};
        tbl[11] = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 16'h1111, 16'hA5A5, 1, 2'b01, 0, 16'h1111, 2'b01, 0};
        tbl[12] = '{0, 2'b00, 2'b00, 2'b00, 2'b00, 16'h1111, 16'hA5A5, 1, 2'b01, 0, 16'h1111, 2'b01, 0};
        tbl[13] = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 16'h1111, 16'hA5A5, 1, 2'b00, 0, 16'h0000, 2'b00, 0};
        tbl[14] = '{1, 2'b00, 2'b00, 2'b00, 2'b00, 16'h1111, 16'hA5A5, 0, 2'b01, 0, 16'h1111, 2'b00, 0};

        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);

        // Table: reset, single-beat packet, alternation, missing start, reset mid-packet.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].nrst, tbl[i].req, tbl[i].vld, tbl[i].st, tbl[i].ls,
                  tbl[i].rdy, tbl[i].d0, tbl[i].d1);
            chk($sformatf("vec%0d", i),
                64'({grant_o, valid_o, data_o, ready_o, cancel_o}),
                64'({tbl[i].eg, tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].ec}));
        end

        // Timeout: one beat, then the requester goes silent for TO cycles.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 2'b01, 0, 0, 0, 1, 16'h1111, 0);
        drive(1, 2'b01, 2'b01, 2'b01, 0, 1, 16'h1111, 0);
        chk("to_first_beat", 64'({grant_o, valid_o, ready_o}), 64'({2'b01, 1'b1, 2'b01}));
        for (int k = 1; k <= TO; k++) begin
            drive(1, 2'b01, 0, 0, 0, 1, 16'h1111, 0);
            chk($sformatf("to_wait%0d", k), 64'({grant_o, cancel_o}), 64'({2'b01, 1'b0}));
        end
        drive(1, 2'b01, 0, 0, 0, 1, 16'h1111, 0);
        chk("to_cancel", 64'({grant_o, cancel_o, valid_o}), 64'({2'b00, 1'b1, 1'b0}));

        // Beat arriving on the last tolerated idle cycle wins over the timeout.
        drive(1, 2'b01, 2'b01, 2'b01, 0, 1, 16'h2222, 0);
        chk("tb_regrant", 64'({grant_o, cancel_o, valid_o, ready_o}), 64'({2'b01, 1'b0, 1'b1, 2'b01}));
        for (int k = 1; k < TO; k++) begin
            drive(1, 2'b01, 0, 0, 0, 1, 16'h2222, 0);
            chk("tb_wait", 64'({grant_o, cancel_o}), 64'({2'b01, 1'b0}));
        end
        drive(1, 2'b01, 2'b01, 0, 0, 1, 16'h3333, 0);
        chk("tb_beat_at_limit", 64'({grant_o, cancel_o, valid_o, ready_o}), 64'({2'b01, 1'b0, 1'b1, 2'b01}));
        drive(1, 2'b01, 2'b01, 0, 2'b01, 1, 16'h4444, 0);
        chk("tb_after", 64'({grant_o, cancel_o, data_o}), 64'({2'b01, 1'b0, 16'h4444}));
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        chk("tb_done", 64'({grant_o, cancel_o}), 64'({2'b00, 1'b0}));

        // Downstream stall of 10 cycles mid-packet.
        drive(1, 2'b10, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 2'b10, 2'b10, 0, 1, 0, 16'hBEEF);
        chk("st_first", 64'({grant_o, valid_o, ready_o}), 64'({2'b10, 1'b1, 2'b10}));
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 2'b10, 0, 0, 0, 0, 16'hC0DE);
            chk("st_hold", 64'({ready_o, valid_o, data_o, cancel_o}), 64'({2'b00, 1'b1, 16'hC0DE, 1'b0}));
        end
        drive(1, 0, 2'b10, 0, 2'b10, 1, 0, 16'hC0DE);
        chk("st_release", 64'({ready_o, data_o, last_o}), 64'({2'b10, 16'hC0DE, 1'b1}));
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        chk("st_done", 64'({grant_o, cancel_o}), 64'({2'b00, 1'b0}));

        // Randomized run against the model, starting from a fresh reset.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        model_step();
        stall_left = 0;
        for (int n = 0; n < 3000; n++) begin
            r = 2'($urandom);
            v = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            s = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            l = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            if (stall_left == 0 && $urandom_range(0, 39) == 0) stall_left = 10;
            len_i = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            drive(($urandom_range(0, 299) != 0), r, v, s, l,
                  (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom));
            if (stall_left > 0) stall_left--;
            model_check();
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_pkt_arb.md
TX_PKT_ARB -- requirements
Module: tx_pkt_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus width; only 16 supported.
REQ-002 SHALL have parameter N_REQ, default 2, number of requesters, range 2..4.
REQ-003 SHALL have parameter TIMEOUT, default 64, idle cycles tolerated mid-packet; LEN_W = clog2(DATA_W/8+1).
REQ-004 clk  in  1  clock.
REQ-005 nreset  in  1  reset, synchronous, active-low.
REQ-006 req_i  in  N_REQ  per-requester packet pending.
REQ-007 valid_i, start_i, last_i  in  N_REQ each  per-requester beat valid, first beat, final beat.
REQ-008 data_i  in  N_REQ*DATA_W; len_i  in  N_REQ*LEN_W  per-requester data and valid bytes, requester i at slice i.
REQ-009 grant_o  out  N_REQ  one-hot current owner; ready_o  out  N_REQ  per-requester beat accepted.
REQ-010 valid_o, start_o, last_o  out  1 each; data_o  out  DATA_W; len_o  out  LEN_W  to IPv4 TX.
REQ-011 ready_i  in  1  downstream accepts beat; cancel_o  out  1  abort current packet downstream.

Function
REQ-012 FSM states IDLE, XFER; one-hot or encoded, exactly one active.
REQ-013 IDLE: if any req_i, pick winner round-robin starting at index ptr_q+1 mod N_REQ, set grant_q, go XFER next cycle.
REQ-014 IDLE with no req_i: stay IDLE, grant_o = 0.
REQ-015 req_i SHALL be sampled only in IDLE; changes during XFER ignored.
REQ-016 Output mux combinational from granted slice: valid_o = valid_i[g] & XFER; start_o, last_o, data_o, len_o from slice g; data_o/len_o = 0 when no grant.
REQ-017 ready_o[i] = grant_q[i] & ready_i & XFER; beat accepted when valid_o & ready_i.
REQ-018 Accepted beat with last_o: go IDLE next cycle, ptr_q <= g; at least one IDLE cycle between packets.
REQ-019 Single-beat packet (start and last same beat) SHALL complete normally.
REQ-020 Idle counter (clog2(TIMEOUT+1) bits) clears on entry to XFER and on each accepted beat; increments on XFER cycles with no accepted beat; saturates.
REQ-021 Counter reaching TIMEOUT: cancel_o = 1 for exactly one cycle (registered), FSM to IDLE, ptr_q <= g, grant cleared same cycle as cancel_o.
REQ-022 Accepted beat and timeout same cycle: beat wins, counter clears, no cancel.
REQ-023 ready_i low stalls: outputs held by requester, counter still increments (stall counts toward timeout).
REQ-024 First accepted beat lacking start_i: treated as protocol error, cancel_o pulse, to IDLE.
REQ-025 Zero-latency datapath; grant latency one cycle from req_i high in IDLE.

Reset
REQ-026 nreset low: FSM IDLE, grant_q 0, ptr_q = N_REQ-1 (requester 0 first), counter 0, cancel_o 0.
REQ-027 All outputs 0 during and one cycle after reset; reset mid-packet drops grant without cancel_o.

Structure
REQ-028 DATA_W, LEN_W derivation and state encoding in shared package eth_pkg.
REQ-029 Round-robin priority pick in sub-module rr_pick (req vector, pointer -> one-hot winner), combinational.

Verification
REQ-030 req_i=2'b11 from reset, 3-beat packets each -> grant 0 first, then 1, alternating, one IDLE cycle between.
REQ-031 Single requester 1, data 16'hA5A5 one beat start+last -> valid_o one cycle, grant drops next cycle.
REQ-032 Granted requester stops valid after 1 beat, TIMEOUT=64 -> cancel_o high exactly at idle cycle 64, grant_o 0.
REQ-033 ready_i low 10 cycles mid-packet -> data_o stable, ready_o 0, no beat lost or duplicated.
REQ-034 First beat without start_i -> cancel_o pulse, return IDLE, ptr advances past offender.
REQ-035 nreset asserted mid-packet -> all outputs 0, next grant to requester 0.
